// File: rtl/wb_word_reader.sv
// Wishbone classic read initiator: fetches a run of consecutive 32-bit words
// and hands them one at a time to a valid/ready consumer.
module wb_word_reader #(
  parameter int unsigned BUS_WID  = 32,
  parameter int unsigned WORD_WID = 32,
  parameter int unsigned LEN_WID  = 16
) (
  input  logic                clk,
  input  logic                rst_L,
  input  logic                start,
  input  logic [BUS_WID-1:0]  base_addr,
  input  logic [LEN_WID-1:0]  len,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORD_WID-1:0] out_data,
  output logic                wb_cyc,
  output logic                wb_stb,
  output logic                wb_we,
  output logic [3:0]          wb_sel,
  output logic [BUS_WID-1:0]  wb_addr,
  output logic [BUS_WID-1:0]  wb_dat_w,
  input  logic                wb_ack,
  input  logic [BUS_WID-1:0]  wb_dat_r
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_RELEASE = 2'd2,
    S_FINISH  = 2'd3
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [BUS_WID-1:0]  r_addr, w_addr_nxt;
  logic [LEN_WID-1:0]  r_remaining, w_remaining_nxt;
  logic                r_abort_pend, w_abort_pend_nxt;
  logic                r_stb, w_stb_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_done, w_done_nxt;
  logic                r_out_valid, w_out_valid_nxt;
  logic [WORD_WID-1:0] r_out_data, w_out_data_nxt;
  logic                w_buf_free;

  // The output buffer can take a new word if empty or being consumed this cycle.
  assign w_buf_free = !r_out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_remaining  <= '0;
      r_abort_pend <= 1'b0;
      r_stb        <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_addr       <= w_addr_nxt;
      r_remaining  <= w_remaining_nxt;
      r_abort_pend <= w_abort_pend_nxt;
      r_stb        <= w_stb_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_out_valid  <= w_out_valid_nxt;
      r_out_data   <= w_out_data_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_addr_nxt       = r_addr;
    w_remaining_nxt  = r_remaining;
    w_abort_pend_nxt = r_abort_pend;
    w_stb_nxt        = r_stb;
    w_out_valid_nxt  = r_out_valid && !out_ready;
    w_out_data_nxt   = r_out_data;

    case (r_state)
      S_IDLE: begin
        w_abort_pend_nxt = 1'b0;
        if (start) begin
          w_addr_nxt      = base_addr & ~BUS_WID'(3);
          w_remaining_nxt = len;
          if (len == '0) begin
            w_state_nxt = S_FINISH;
          end else begin
            w_state_nxt = S_REQ;
            w_stb_nxt   = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (abort) w_abort_pend_nxt = 1'b1;
        // Ack is held by the responder, so a full buffer simply stretches REQ.
        if (wb_ack && w_buf_free) begin
          w_out_data_nxt  = wb_dat_r[WORD_WID-1:0];
          w_out_valid_nxt = 1'b1;
          w_remaining_nxt = r_remaining - LEN_WID'(1);
          w_addr_nxt      = r_addr + BUS_WID'(4);
          w_stb_nxt       = 1'b0;
          w_state_nxt     = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (abort) w_abort_pend_nxt = 1'b1;
        if (!wb_ack && w_buf_free) begin
          if (r_remaining == '0 || abort || r_abort_pend) begin
            w_state_nxt = S_FINISH;
          end else begin
            w_state_nxt = S_REQ;
            w_stb_nxt   = 1'b1;
          end
        end
      end
      S_FINISH: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_stb_nxt   = 1'b0;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_done_nxt = (w_state_nxt == S_FINISH);
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign wb_cyc    = r_stb;
  assign wb_stb    = r_stb;
  assign wb_we     = 1'b0;
  assign wb_sel    = 4'hF;
  assign wb_addr   = r_addr;
  assign wb_dat_w  = '0;

endmodule

// File: tb/tb_wb_word_reader.sv
// Directed bench for wb_word_reader with a 16-word RAM responder model and
// address/data scoreboards checked as requests and stream handshakes occur.
module tb_wb_word_reader;

  logic        clk = 1'b0;
  logic        rst_L = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] len = '0;
  logic        abort = 1'b0;
  logic        busy, done, out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        wb_cyc, wb_stb, wb_we;
  logic [3:0]  wb_sel;
  logic [31:0] wb_addr, wb_dat_w;
  logic        wb_ack;
  logic [31:0] wb_dat_r;

  wb_word_reader dut (
    .clk(clk), .rst_L(rst_L), .start(start), .base_addr(base_addr), .len(len),
    .abort(abort), .busy(busy), .done(done), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .wb_cyc(wb_cyc), .wb_stb(wb_stb),
    .wb_we(wb_we), .wb_sel(wb_sel), .wb_addr(wb_addr), .wb_dat_w(wb_dat_w),
    .wb_ack(wb_ack), .wb_dat_r(wb_dat_r)
  );

  always #5 clk = ~clk;

  // Responder: word RAM indexed by addr[5:2], ack after wait_cfg extra cycles, held until stb drops.
  logic [31:0] ram [16];
  int          wait_cfg = 0;
  int          wait_cnt;
  always @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      wb_ack   <= 1'b0;
      wb_dat_r <= '0;
      wait_cnt <= 0;
    end else if (!wb_stb) begin
      wb_ack   <= 1'b0;
      wait_cnt <= 0;
    end else if (!wb_ack) begin
      if (wait_cnt >= wait_cfg) begin
        wb_ack   <= 1'b1;
        wb_dat_r <= ram[wb_addr[5:2]];
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end
  end

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_addr [$];
  logic [31:0] exp_data [$];
  int          cyc_n = 0;
  int          req_cnt = 0;
  int          done_cnt = 0;
  int          last_req = 0;
  bit          chk_period = 0;
  logic        prev_stb = 1'b0;
  logic        prev_valid = 1'b0;
  logic        prev_hs = 1'b0;
  logic [31:0] prev_data = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: observe at the falling edge, return just after the rising edge.
  task automatic tick();
    logic [31:0] e;
    logic        hs;
    @(negedge clk);
    cyc_n++;
    if (wb_stb && !prev_stb) begin
      req_cnt++;
      e = 'x;
      if (exp_addr.size() > 0) e = exp_addr.pop_front();
      chk("wb_addr", wb_addr, e);
      chk("wb_we", 32'(wb_we), 32'd0);
      chk("wb_sel", 32'(wb_sel), 32'hF);
      chk("wb_dat_w", wb_dat_w, 32'd0);
      chk("cyc_eq_stb", 32'(wb_cyc), 32'(wb_stb));
      if (chk_period && req_cnt > 1) chk("req_period", 32'(cyc_n - last_req), 32'd4);
      last_req = cyc_n;
    end
    if (prev_valid && !prev_hs && out_valid) chk("data_hold", out_data, prev_data);
    hs = out_valid && out_ready;
    if (hs) begin
      e = 'x;
      if (exp_data.size() > 0) e = exp_data.pop_front();
      chk("out_data", out_data, e);
    end
    if (done) begin
      done_cnt++;
      chk("busy_with_done", 32'(busy), 32'd1);
    end
    prev_stb   = wb_stb;
    prev_valid = out_valid;
    prev_hs    = hs;
    prev_data  = out_data;
    @(posedge clk);
    #1;
  endtask

  task automatic begin_run();
    req_cnt  = 0;
    done_cnt = 0;
    last_req = 0;
  endtask

  task automatic pulse_start(input logic [31:0] a, input logic [15:0] n);
    base_addr = a;
    len       = n;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy || out_valid) && n < budget) begin
      tick();
      n++;
    end
    chk("idle_reached", {30'd0, busy, out_valid}, 32'd0);
  endtask

  task automatic wait_reqs(input int count, input int budget);
    int n = 0;
    while (req_cnt < count && n < budget) begin
      tick();
      n++;
    end
    chk("req_reached", 32'(req_cnt), 32'(count));
  endtask

  task automatic end_run(input int reqs);
    chk("req_count", 32'(req_cnt), 32'(reqs));
    chk("done_count", 32'(done_cnt), 32'd1);
    chk("addr_q_empty", 32'(exp_addr.size()), 32'd0);
    chk("data_q_empty", 32'(exp_data.size()), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ram[i] = 32'hA000_0000 + 32'(i) * 32'h0101;
    ram[0] = 32'h1111_1111;
    ram[1] = 32'h2222_2222;
    ram[2] = 32'h3333_3333;
    ram[3] = 32'h4444_4444;

    // Reset values
    tick(); tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_stb", 32'({wb_cyc, wb_stb}), 32'd0);
    chk("rst_addr", wb_addr, 32'd0);
    rst_L = 1'b1;
    tick();

    // Four-word run at 0x100 with a zero-wait responder
    begin_run();
    out_ready  = 1'b1;
    chk_period = 1;
    for (int i = 0; i < 4; i++) begin
      exp_addr.push_back(32'h100 + 32'(i) * 4);
      exp_data.push_back(ram[i]);
    end
    pulse_start(32'h100, 16'd4);
    chk("stb_cycle1", 32'(wb_stb), 32'd1);
    chk("busy_cycle1", 32'(busy), 32'd1);
    wait_idle(60);
    end_run(4);
    chk_period = 0;

    // Zero-length run: done next cycle, no bus traffic
    begin_run();
    pulse_start(32'h100, 16'd0);
    chk("len0_done", 32'(done), 32'd1);
    chk("len0_busy", 32'(busy), 32'd1);
    chk("len0_cyc", 32'(wb_cyc), 32'd0);
    tick();
    chk("len0_done_off", 32'(done), 32'd0);
    chk("len0_busy_off", 32'(busy), 32'd0);
    tick();
    end_run(0);

    // Backpressure: consumer stalls 10 cycles after the first word
    begin_run();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_addr.push_back(32'h210 + 32'(i) * 4);
      exp_data.push_back(ram[4 + i]);
    end
    pulse_start(32'h210, 16'd3);
    for (int n = 0; n < 20 && !out_valid; n++) tick();
    chk("bp_first_valid", 32'(out_valid), 32'd1);
    for (int n = 0; n < 10; n++) tick();
    chk("bp_no_new_req", 32'(req_cnt), 32'd1);
    chk("bp_stb_low", 32'(wb_stb), 32'd0);
    out_ready = 1'b1;
    wait_idle(60);
    end_run(3);

    // Abort during the second request of an 8-word run, responder with wait states
    begin_run();
    wait_cfg = 2;
    for (int i = 0; i < 2; i++) begin
      exp_addr.push_back(32'h100 + 32'(i) * 4);
      exp_data.push_back(ram[i]);
    end
    pulse_start(32'h100, 16'd8);
    wait_reqs(2, 40);
    chk("abort_in_req", 32'(wb_stb), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_idle(60);
    for (int n = 0; n < 4; n++) tick();
    end_run(2);
    wait_cfg = 0;

    // Address wrap at the top of the space; restart while busy is ignored
    begin_run();
    exp_addr.push_back(32'hFFFF_FFFC);
    exp_addr.push_back(32'h0000_0000);
    exp_data.push_back(ram[15]);
    exp_data.push_back(ram[0]);
    pulse_start(32'hFFFF_FFFE, 16'd2);
    tick();
    pulse_start(32'h300, 16'd5);
    wait_idle(60);
    for (int n = 0; n < 4; n++) tick();
    end_run(2);

    // Asynchronous reset while a request is outstanding
    begin_run();
    exp_addr.push_back(32'h100);
    pulse_start(32'h100, 16'd4);
    wait_reqs(1, 10);
    chk("prerst_stb", 32'(wb_stb), 32'd1);
    #1 rst_L = 1'b0;
    #1;
    chk("arst_stb", 32'({wb_cyc, wb_stb}), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_addr", wb_addr, 32'd0);
    tick();
    rst_L = 1'b1;
    for (int n = 0; n < 8; n++) tick();
    chk("arst_no_done", 32'(done_cnt), 32'd0);
    chk("arst_no_req", 32'(req_cnt), 32'd1);
    chk("arst_idle", 32'({busy, out_valid, wb_stb}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wb_word_reader.md
# wb_word_reader

Wishbone classic initiator that fetches a run of consecutive 32-bit words from a word-addressed Wishbone responder (the block RAM buffers) and presents them one at a time on a valid/ready stream. It sits between a RAM slave port and a consumer such as a waveform or DAC sequencer. Reads only, aligned accesses only, one outstanding transfer at a time.

## Interface
- BUS_WID, 32, width of wb_addr, wb_dat_r, base_addr.
- WORD_WID, 32, width of out_data; low WORD_WID bits of wb_dat_r.
- LEN_WID, 16, width of len; maximum run is 2^LEN_WID-1 words.
- clk  in  1  sole clock, all logic rising-edge.
- rst_L  in  1  reset, asynchronous, active-low.
- start  in  1  begin a run; sampled only in IDLE.
- base_addr  in  BUS_WID  byte address of first word; bits [1:0] ignored and treated as 0.
- len  in  LEN_WID  number of words; sampled with start.
- abort  in  1  stop the run at the next word boundary.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a run ends, normally or by abort.
- out_valid  out  1  out_data holds an unconsumed word.
- out_ready  in  1  consumer accepts word when out_valid && out_ready.
- out_data  out  WORD_WID  fetched word.
- wb_cyc, wb_stb  out  1  bus request; always equal.
- wb_we  out  1  constant 0.
- wb_sel  out  4  constant 4'hF.
- wb_addr  out  BUS_WID  current byte address.
- wb_dat_w  out  BUS_WID  constant 0.
- wb_ack  in  1  responder acknowledge; held until stb falls.
- wb_dat_r  in  BUS_WID  read data, valid while wb_ack.

## Operation
- All outputs registered. Reset values: busy 0, done 0, out_valid 0, out_data 0, wb_cyc/wb_stb 0, wb_addr 0; state IDLE, word counter 0.
- States: IDLE, REQ, RELEASE, FINISH.
- IDLE: on start, latch addr = base_addr & ~3, remaining = len. If len==0 go FINISH, no bus traffic. Else go REQ with cyc/stb high.
- REQ: hold cyc/stb, wb_addr stable. On wb_ack: out_data <= wb_dat_r[WORD_WID-1:0], out_valid <= 1, remaining -= 1, addr += 4, cyc/stb <= 0, go RELEASE.
- RELEASE: wait until wb_ack==0 and (out_valid==0 or out_ready). Then: remaining==0 or abort -> FINISH; else REQ.
- FINISH: done=1 for exactly one cycle, then IDLE. out_valid may still be high; word stays until consumed, then out_valid clears.
- Stream: out_valid clears on the cycle after out_valid && out_ready in any state. out_data never changes while out_valid high.
- Address arithmetic modulo 2^BUS_WID; incrementing past all-ones wraps to 0, no error.
- start while busy ignored. abort in IDLE ignored. abort in REQ does not drop stb; the pending transfer completes and its word is delivered.
- Async reset mid-run: cyc/stb fall immediately, pending word discarded, no done pulse.

## Timing
- start in cycle 0 -> REQ, stb high in cycle 1.
- Zero-wait responder (ack registered one cycle after stb): ack seen cycle 2, out_valid high cycle 3, stb low cycle 3, ack low cycle 4, next stb cycle 5 if out_ready held. Steady state 4 cycles/word.
- Responder wait states extend REQ arbitrarily; no timeout.
- Backpressure: with out_ready low, no new request issued; at most one buffered word.
- done asserts the cycle after leaving RELEASE on the final word; busy falls same cycle done falls.

## Test plan
- Reset: rst_L low mid-REQ -> wb_stb 0 asynchronously, all outputs 0, no done after release.
- base_addr 0x100, len 4, RAM words 0x11111111..0x44444444, out_ready=1 -> addrs 0x100,0x104,0x108,0x10C, data in order, 4 cycles/word, one done pulse, wb_we 0, wb_sel F.
- len 0 -> done one cycle after start, wb_cyc never high.
- Backpressure: len 3, out_ready low 10 cycles after first word -> stb stays low, out_data stable, then remaining 2 words delivered.
- abort during second REQ of len 8 -> second word delivered, no third request, done once.
- base_addr 0xFFFFFFFE, len 2 -> addrs 0xFFFFFFFC then 0x00000000; start pulsed while busy has no effect.
